// File: rtl/cam_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cam_ctrl_pkg
//  Purpose  : Shared types for the CAM command sequencer: command opcodes,
//             sequencer states and the row-count derivation.
//  Revision : 1.0  initial release
// ============================================================================
package cam_ctrl_pkg;

    // Command opcodes as they appear on cmd_op_i
    typedef enum logic [1:0] {
        OP_LOOKUP = 2'b00,
        OP_INSERT = 2'b01,
        OP_READ   = 2'b10,
        OP_RSVD   = 2'b11
    } cam_op_e;

    // Sequencer states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SRCH  = 3'd1,
        ST_CHK   = 3'd2,
        ST_WR    = 3'd3,
        ST_RD    = 3'd4,
        ST_RDCAP = 3'd5,
        ST_RESP  = 3'd6
    } cam_ctrl_state_e;

    // Number of CAM rows addressed by an index of the given width
    function automatic int cam_depth(input int addr_width);
        return 1 << addr_width;
    endfunction

endpackage : cam_ctrl_pkg
`default_nettype wire

// File: rtl/cam_free_finder.sv
`default_nettype none
// ============================================================================
//  Module   : cam_free_finder
//  Purpose  : Combinational lowest-zero finder over the occupancy bitmap.
//  Ports    : i_occ        - occupancy bitmap, one bit per CAM row
//             o_free_index - lowest row whose occupancy bit is 0
//             o_any_free   - at least one row is free
//  Revision : 1.0  initial release
// ============================================================================
module cam_free_finder
    import cam_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 5,
    localparam int DEPTH     = cam_depth(ADDR_WIDTH)
) (
    input  logic [DEPTH-1:0]      i_occ,
    output logic [ADDR_WIDTH-1:0] o_free_index,
    output logic                  o_any_free
);

    logic [ADDR_WIDTH-1:0] w_free_index;
    logic                  w_any_free;

    // Scan from the top down so the last hit written is the lowest free row
    always_comb begin
        w_free_index = '0;
        w_any_free   = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!i_occ[i]) begin
                w_free_index = ADDR_WIDTH'(i);
                w_any_free   = 1'b1;
            end
        end
    end

    assign o_free_index = w_free_index;
    assign o_any_free   = w_any_free;

endmodule : cam_free_finder
`default_nettype wire

// File: rtl/cam_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : cam_ctrl
//  Purpose  : Command-level sequencer in front of a CAM. Accepts LOOKUP,
//             INSERT and READ commands, drives the CAM search/write/read
//             ports in a fixed cycle sequence, tracks row occupancy to
//             allocate free rows (round-robin eviction when full) and returns
//             one response per command.
//  Ports    : clk_i, rst_i                    - clock, sync active-high reset
//             cmd_*                           - command valid/ready channel
//             rsp_*                           - response valid/ready channel
//             cam_read_* / cam_write_* /
//             cam_search_*                    - CAM port drive and results
//  Revision : 1.0  initial release
// ============================================================================
module cam_ctrl
    import cam_ctrl_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    // command channel
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic [1:0]            cmd_op_i,
    input  logic [WIDTH-1:0]      cmd_key_i,
    input  logic [ADDR_WIDTH-1:0] cmd_index_i,
    // response channel
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic                  rsp_hit_o,
    output logic [ADDR_WIDTH-1:0] rsp_index_o,
    output logic [WIDTH-1:0]      rsp_data_o,
    output logic                  rsp_evict_o,
    output logic                  rsp_err_o,
    // CAM drive
    output logic                  cam_read_enable_o,
    output logic [ADDR_WIDTH-1:0] cam_read_index_o,
    output logic                  cam_write_enable_o,
    output logic [ADDR_WIDTH-1:0] cam_write_index_o,
    output logic [WIDTH-1:0]      cam_write_data_o,
    output logic                  cam_search_enable_o,
    output logic [WIDTH-1:0]      cam_search_data_o,
    // CAM results
    input  logic                  cam_read_valid_i,
    input  logic [WIDTH-1:0]      cam_read_value_i,
    input  logic                  cam_search_valid_i,
    input  logic [ADDR_WIDTH-1:0] cam_search_index_i
);

    localparam int DEPTH = cam_depth(ADDR_WIDTH);

    cam_ctrl_state_e       r_state;
    cam_op_e               r_op;
    logic [WIDTH-1:0]      r_key;
    logic [ADDR_WIDTH-1:0] r_index;
    logic [DEPTH-1:0]      r_occ;
    logic [ADDR_WIDTH-1:0] r_rr;

    logic                  r_cmd_ready;
    logic                  r_rsp_valid;
    logic                  r_rsp_hit;
    logic [ADDR_WIDTH-1:0] r_rsp_index;
    logic [WIDTH-1:0]      r_rsp_data;
    logic                  r_rsp_evict;
    logic                  r_rsp_err;
    logic                  r_rd_en;
    logic [ADDR_WIDTH-1:0] r_rd_index;
    logic                  r_wr_en;
    logic [ADDR_WIDTH-1:0] r_wr_index;
    logic [WIDTH-1:0]      r_wr_data;
    logic                  r_srch_en;
    logic [WIDTH-1:0]      r_srch_data;

    logic [ADDR_WIDTH-1:0] w_free_index;
    logic                  w_any_free;
    logic [ADDR_WIDTH-1:0] w_target;

    cam_free_finder #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_free_finder (
        .i_occ        (r_occ),
        .o_free_index (w_free_index),
        .o_any_free   (w_any_free)
    );

    // A free row always wins; only a full CAM falls back to the round-robin victim
    assign w_target = w_any_free ? w_free_index : r_rr;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= ST_IDLE;
            r_op        <= OP_LOOKUP;
            r_key       <= '0;
            r_index     <= '0;
            r_occ       <= '0;
            r_rr        <= '0;
            r_cmd_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_hit   <= 1'b0;
            r_rsp_index <= '0;
            r_rsp_data  <= '0;
            r_rsp_evict <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rd_en     <= 1'b0;
            r_rd_index  <= '0;
            r_wr_en     <= 1'b0;
            r_wr_index  <= '0;
            r_wr_data   <= '0;
            r_srch_en   <= 1'b0;
            r_srch_data <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid_i) begin
                        r_cmd_ready <= 1'b0;
                        r_op        <= cam_op_e'(cmd_op_i);
                        r_key       <= cmd_key_i;
                        r_index     <= cmd_index_i;
                        case (cam_op_e'(cmd_op_i))
                            OP_LOOKUP, OP_INSERT: begin
                                r_state     <= ST_SRCH;
                                r_srch_en   <= 1'b1;
                                r_srch_data <= cmd_key_i;
                            end
                            OP_READ: begin
                                r_state    <= ST_RD;
                                r_rd_en    <= 1'b1;
                                r_rd_index <= cmd_index_i;
                            end
                            default: begin
                                r_state     <= ST_RESP;
                                r_rsp_valid <= 1'b1;
                                r_rsp_err   <= 1'b1;
                            end
                        endcase
                    end
                end

                ST_SRCH: begin
                    // CAM registers the search result at this edge
                    r_srch_en   <= 1'b0;
                    r_srch_data <= '0;
                    r_state     <= ST_CHK;
                end

                ST_CHK: begin
                    if (cam_search_valid_i) begin
                        // Key present: report it, never write (even for INSERT)
                        r_rsp_hit   <= 1'b1;
                        r_rsp_index <= cam_search_index_i;
                        r_rsp_valid <= 1'b1;
                        r_state     <= ST_RESP;
                    end else if (r_op == OP_INSERT) begin
                        r_rsp_evict <= ~w_any_free;
                        if (!w_any_free) begin
                            r_rr <= r_rr + ADDR_WIDTH'(1);
                        end
                        r_wr_en    <= 1'b1;
                        r_wr_index <= w_target;
                        r_wr_data  <= r_key;
                        r_state    <= ST_WR;
                    end else begin
                        r_rsp_hit   <= 1'b0;
                        r_rsp_index <= '0;
                        r_rsp_valid <= 1'b1;
                        r_state     <= ST_RESP;
                    end
                end

                ST_WR: begin
                    r_occ[r_wr_index] <= 1'b1;
                    r_rsp_index       <= r_wr_index;
                    r_wr_en           <= 1'b0;
                    r_wr_index        <= '0;
                    r_wr_data         <= '0;
                    r_rsp_valid       <= 1'b1;
                    r_state           <= ST_RESP;
                end

                ST_RD: begin
                    r_rd_en    <= 1'b0;
                    r_rd_index <= '0;
                    r_state    <= ST_RDCAP;
                end

                ST_RDCAP: begin
                    r_rsp_data  <= cam_read_value_i;
                    r_rsp_hit   <= cam_read_valid_i;
                    r_rsp_index <= r_index;
                    r_rsp_valid <= 1'b1;
                    r_state     <= ST_RESP;
                end

                ST_RESP: begin
                    if (rsp_ready_i) begin
                        r_rsp_valid <= 1'b0;
                        r_rsp_hit   <= 1'b0;
                        r_rsp_index <= '0;
                        r_rsp_data  <= '0;
                        r_rsp_evict <= 1'b0;
                        r_rsp_err   <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end

                default: begin
                    r_state     <= ST_IDLE;
                    r_cmd_ready <= 1'b1;
                end
            endcase
        end
    end

    assign cmd_ready_o         = r_cmd_ready;
    assign rsp_valid_o         = r_rsp_valid;
    assign rsp_hit_o           = r_rsp_hit;
    assign rsp_index_o         = r_rsp_index;
    assign rsp_data_o          = r_rsp_data;
    assign rsp_evict_o         = r_rsp_evict;
    assign rsp_err_o           = r_rsp_err;
    assign cam_read_enable_o   = r_rd_en;
    assign cam_read_index_o    = r_rd_index;
    assign cam_write_enable_o  = r_wr_en;
    assign cam_write_index_o   = r_wr_index;
    assign cam_write_data_o    = r_wr_data;
    assign cam_search_enable_o = r_srch_en;
    assign cam_search_data_o   = r_srch_data;

endmodule : cam_ctrl
`default_nettype wire

// File: tb/tb_cam_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cam_ctrl
//  Purpose  : Self-checking bench for cam_ctrl with a behavioural CAM attached
//             and a command-level reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_cam_ctrl;

    localparam int W  = 32;
    localparam int AW = 5;
    localparam int N  = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [1:0]    cmd_op = 2'b00;
    logic [W-1:0]  cmd_key = '0;
    logic [AW-1:0] cmd_index = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic          rsp_hit;
    logic [AW-1:0] rsp_index;
    logic [W-1:0]  rsp_data;
    logic          rsp_evict;
    logic          rsp_err;
    logic          re, we, se;
    logic [AW-1:0] ri, wi;
    logic [W-1:0]  wd, sd;
    logic          cam_rv, cam_sv;
    logic [W-1:0]  cam_rd;
    logic [AW-1:0] cam_si;

    always #5 clk = ~clk;

    cam_ctrl #(.WIDTH(W), .ADDR_WIDTH(AW)) dut (
        .clk_i               (clk),
        .rst_i               (rst),
        .cmd_valid_i         (cmd_valid),
        .cmd_ready_o         (cmd_ready),
        .cmd_op_i            (cmd_op),
        .cmd_key_i           (cmd_key),
        .cmd_index_i         (cmd_index),
        .rsp_valid_o         (rsp_valid),
        .rsp_ready_i         (rsp_ready),
        .rsp_hit_o           (rsp_hit),
        .rsp_index_o         (rsp_index),
        .rsp_data_o          (rsp_data),
        .rsp_evict_o         (rsp_evict),
        .rsp_err_o           (rsp_err),
        .cam_read_enable_o   (re),
        .cam_read_index_o    (ri),
        .cam_write_enable_o  (we),
        .cam_write_index_o   (wi),
        .cam_write_data_o    (wd),
        .cam_search_enable_o (se),
        .cam_search_data_o   (sd),
        .cam_read_valid_i    (cam_rv),
        .cam_read_value_i    (cam_rd),
        .cam_search_valid_i  (cam_sv),
        .cam_search_index_i  (cam_si)
    );

    // ---------------- behavioural CAM (registered results) ----------------
    logic [W-1:0] cam_val [N];
    logic         cam_vld [N];

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                cam_vld[i] <= 1'b0;
                cam_val[i] <= '0;
            end
            cam_sv <= 1'b0;
            cam_si <= '0;
            cam_rv <= 1'b0;
            cam_rd <= '0;
        end else begin
            cam_sv <= 1'b0;
            cam_si <= '0;
            cam_rv <= 1'b0;
            if (se) begin
                for (int i = N - 1; i >= 0; i--) begin
                    if (cam_vld[i] && cam_val[i] == sd) begin
                        cam_sv <= 1'b1;
                        cam_si <= AW'(i);
                    end
                end
            end
            if (re) begin
                cam_rv <= cam_vld[ri];
                cam_rd <= cam_val[ri];
            end
            if (we) begin
                cam_vld[wi] <= 1'b1;
                cam_val[wi] <= wd;
            end
        end
    end

    // ---------------- monitors ----------------
    int wr_pulses = 0;
    int excl_viol = 0;
    always @(posedge clk) begin
        if (!rst) begin
            wr_pulses <= wr_pulses + (we ? 1 : 0);
            excl_viol <= excl_viol + ((int'(re) + int'(we) + int'(se)) > 1 ? 1 : 0);
        end
    end

    // ---------------- checking ----------------
    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // ---------------- command-level reference model ----------------
    logic [W-1:0] m_key [N];
    bit           m_vld [N];
    int           m_rr;

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_vld[i] = 1'b0;
            m_key[i] = '0;
        end
        m_rr = 0;
    endtask

    // Predicts one command's response and its cost in cycles / CAM writes
    task automatic model_cmd(input logic [1:0] op, input logic [W-1:0] key, input int idx,
                             output bit e_hit, output int e_idx, output logic [W-1:0] e_data,
                             output bit e_evict, output bit e_err, output int e_lat, output int e_wr);
        int found;
        e_hit = 0; e_idx = 0; e_data = '0; e_evict = 0; e_err = 0; e_wr = 0;
        found = -1;
        for (int i = 0; i < N; i++)
            if (found < 0 && m_vld[i] && m_key[i] == key) found = i;
        case (op)
            2'b00: begin
                e_lat = 3;
                if (found >= 0) begin e_hit = 1; e_idx = found; end
            end
            2'b01: begin
                if (found >= 0) begin
                    e_lat = 3; e_hit = 1; e_idx = found;
                end else begin
                    int tgt;
                    e_lat = 4; e_wr = 1;
                    tgt = -1;
                    for (int i = 0; i < N; i++)
                        if (tgt < 0 && !m_vld[i]) tgt = i;
                    if (tgt < 0) begin
                        tgt = m_rr; e_evict = 1; m_rr = (m_rr + 1) % N;
                    end
                    m_vld[tgt] = 1'b1;
                    m_key[tgt] = key;
                    e_idx = tgt;
                end
            end
            2'b10: begin
                e_lat = 3; e_idx = idx; e_hit = m_vld[idx]; e_data = m_key[idx];
            end
            default: begin
                e_lat = 1; e_err = 1;
            end
        endcase
    endtask

    // last observed response, for directed checks
    bit           l_hit, l_evict, l_err;
    int           l_idx;
    logic [W-1:0] l_data;

    task automatic do_cmd(input logic [1:0] op, input logic [W-1:0] key, input int idx, input int hold);
        bit e_hit, e_evict, e_err;
        int e_idx, e_lat, e_wr, lat, wr0;
        logic [W-1:0] e_data;
        logic [63:0]  snap;
        model_cmd(op, key, idx, e_hit, e_idx, e_data, e_evict, e_err, e_lat, e_wr);
        @(negedge clk);
        chk("cmd_ready_idle", 64'(cmd_ready), 64'd1);
        cmd_valid = 1'b1; cmd_op = op; cmd_key = key; cmd_index = AW'(idx);
        wr0 = wr_pulses;
        @(negedge clk);
        cmd_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", 64'(lat), 64'(e_lat));
        chk("rsp_hit", 64'(rsp_hit), 64'(e_hit));
        chk("rsp_index", 64'(rsp_index), 64'(e_idx));
        chk("rsp_data", 64'(rsp_data), 64'(e_data));
        chk("rsp_evict", 64'(rsp_evict), 64'(e_evict));
        chk("rsp_err", 64'(rsp_err), 64'(e_err));
        chk("cmd_ready_busy", 64'(cmd_ready), 64'd0);
        l_hit = rsp_hit; l_idx = int'(rsp_index); l_data = rsp_data;
        l_evict = rsp_evict; l_err = rsp_err;
        snap = {22'd0, rsp_valid, cmd_ready, rsp_hit, rsp_index, rsp_data, rsp_evict, rsp_err};
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("rsp_hold", {22'd0, rsp_valid, cmd_ready, rsp_hit, rsp_index, rsp_data, rsp_evict, rsp_err}, snap);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("wr_pulses", 64'(wr_pulses - wr0), 64'(e_wr));
        chk("rsp_clear", {23'd0, rsp_valid, rsp_hit, rsp_index, rsp_data, rsp_evict, rsp_err}, 64'd0);
        chk("cmd_ready_back", 64'(cmd_ready), 64'd1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        model_reset();
        do_reset();
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("rst_rsp", {56'd0, rsp_valid, rsp_hit, rsp_evict, rsp_err, 4'd0}, 64'd0);
        chk("rst_rsp_idx_data", {27'd0, rsp_index, rsp_data}, 64'd0);
        chk("rst_cam_en", {61'd0, re, we, se}, 64'd0);

        // lookup in empty CAM
        do_cmd(2'b00, 32'hDEADBEEF, 0, 0);
        chk("t1_hit", 64'(l_hit), 64'd0);

        // first inserts fill rows from the bottom
        do_cmd(2'b01, 32'h11, 0, 0); chk("t2_idx0", 64'(l_idx), 64'd0);
        do_cmd(2'b01, 32'h22, 0, 0); chk("t2_idx1", 64'(l_idx), 64'd1);
        do_cmd(2'b01, 32'h33, 0, 0); chk("t2_idx2", 64'(l_idx), 64'd2);
        do_cmd(2'b00, 32'h22, 0, 0); chk("t2_lookup", 64'({l_hit, 5'(l_idx)}), 64'h21);

        // duplicate insert hits and does not write
        do_cmd(2'b01, 32'h22, 0, 0); chk("t3_dup", 64'({l_hit, 5'(l_idx)}), 64'h21);

        // reads of an occupied and an empty row
        do_cmd(2'b10, 32'h0, 2, 0); chk("t5_rd2", 64'({l_hit, l_data}), 64'h1_0000_0033);
        do_cmd(2'b10, 32'h0, 7, 0); chk("t5_rd7", 64'(l_hit), 64'd0);

        // back-pressure and reserved opcode
        do_cmd(2'b00, 32'h11, 0, 5);
        do_cmd(2'b11, 32'h5, 0, 2); chk("t6_err", 64'(l_err), 64'd1);

        // fill from empty, then round-robin eviction
        do_reset();
        for (int k = 0; k < N; k++) do_cmd(2'b01, 32'h100 + 32'(k), 0, 0);
        do_cmd(2'b01, 32'h200, 0, 0); chk("t4_ev0", 64'({l_evict, 5'(l_idx)}), 64'h20);
        do_cmd(2'b01, 32'h201, 0, 0); chk("t4_ev1", 64'({l_evict, 5'(l_idx)}), 64'h21);
        do_cmd(2'b00, 32'h100, 0, 0); chk("t4_gone", 64'(l_hit), 64'd0);

        // reset while the write pulse is out: no response, CAM empty again
        begin
            int  wait_cyc;
            @(negedge clk);
            cmd_valid = 1'b1; cmd_op = 2'b01; cmd_key = 32'h300; cmd_index = '0;
            @(negedge clk);
            cmd_valid = 1'b0;
            wait_cyc = 0;
            while (!we && wait_cyc < 10) begin
                @(negedge clk);
                wait_cyc++;
            end
            chk("t6_wr_seen", 64'(we), 64'd1);
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            model_reset();
            chk("t6_rst_idle", {61'd0, cmd_ready, rsp_valid, we}, 64'h4);
            for (int k = 0; k < 4; k++) @(negedge clk);
            chk("t6_no_rsp", 64'(rsp_valid), 64'd0);
        end
        do_cmd(2'b01, 32'h55, 0, 0); chk("t6_occ_clear", 64'({l_evict, 5'(l_idx)}), 64'h00);

        // randomized traffic over a small key pool to exercise hits and eviction
        for (int n = 0; n < 400; n++) begin
            int          sel;
            logic [1:0]  op;
            sel = int'($urandom_range(0, 9));
            op  = (sel < 4) ? 2'b00 : (sel < 8) ? 2'b01 : (sel == 8) ? 2'b10 : 2'b11;
            do_cmd(op, 32'h1000 + 32'($urandom_range(0, 47)), int'($urandom_range(0, N - 1)),
                   int'($urandom_range(0, 2)));
        end

        chk("cam_en_excl", 64'(excl_viol), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_cam_ctrl
`default_nettype wire

// File: doc/cam_ctrl.md
Name: cam_ctrl

Overview:
Command-level sequencer in front of the 32-entry CAM. It accepts LOOKUP, INSERT and READ commands over a valid/ready handshake, then drives the CAM read, write and search ports in a fixed cycle sequence. It keeps its own occupancy bitmap so INSERT can allocate a free row, or evict round-robin when the CAM is full. Each command returns one response over a valid/ready handshake.

Parameters:
WIDTH, 32, key/data width; matches the CAM WIDTH.
ADDR_WIDTH, 5, CAM index width.
DEPTH, 2**ADDR_WIDTH, number of CAM rows; derived, not overridable.

Ports:
clk_i  in  1  clock; all state updates on its rising edge.
rst_i  in  1  synchronous, active-high reset.
cmd_valid_i  in  1  command present.
cmd_ready_o  out  1  controller can accept a command.
cmd_op_i  in  2  00 LOOKUP, 01 INSERT, 10 READ, 11 reserved.
cmd_key_i  in  WIDTH  search/insert key.
cmd_index_i  in  ADDR_WIDTH  row for READ.
rsp_valid_o  out  1  response present.
rsp_ready_i  in  1  consumer accepts the response.
rsp_hit_o  out  1  LOOKUP/INSERT: key already present; READ: row valid.
rsp_index_o  out  ADDR_WIDTH  matched, allocated or read row.
rsp_data_o  out  WIDTH  READ data; 0 for other ops.
rsp_evict_o  out  1  INSERT overwrote an occupied row.
rsp_err_o  out  1  reserved opcode.
cam_read_enable_o  out  1  to CAM read_enable_i.
cam_read_index_o  out  ADDR_WIDTH  to CAM read_index_i.
cam_write_enable_o  out  1  to CAM write_enable_i.
cam_write_index_o  out  ADDR_WIDTH  to CAM write_index_i.
cam_write_data_o  out  WIDTH  to CAM write_data_i.
cam_search_enable_o  out  1  to CAM search_enable_i.
cam_search_data_o  out  WIDTH  to CAM search_data_i.
cam_read_valid_i  in  1  from CAM read_valid_o.
cam_read_value_i  in  WIDTH  from CAM read_value_o.
cam_search_valid_i  in  1  from CAM search_valid_o.
cam_search_index_i  in  ADDR_WIDTH  from CAM search_index_o.

Behaviour:
- Reset:
  - state = IDLE; occupancy bitmap occ_q = 0; round-robin pointer rr_q = 0.
  - All outputs 0, except cmd_ready_o = 1.
  - Reset mid-command abandons it with no response. The CAM shares rst_i, so both sides agree the CAM is empty.
- States: IDLE, SRCH, CHK, WR, RD, RDCAP, RESP.
- IDLE:
  - cmd_ready_o = 1 only in IDLE.
  - On handshake, register op, key and index.
  - Next state: LOOKUP/INSERT -> SRCH; READ -> RD; reserved -> RESP with rsp_err_o = 1.
- SRCH: cam_search_enable_o = 1 for exactly one cycle; cam_search_data_o = key_q. Next state CHK.
- CHK: sample cam_search_valid_i and cam_search_index_i. The CAM search result is registered one cycle after the enable.
  - Hit: rsp_hit = 1, rsp_index = search index. Next state RESP. No write, even for INSERT.
  - Miss + LOOKUP: rsp_hit = 0, rsp_index = 0. Next state RESP.
  - Miss + INSERT: choose the target row.
    - If occ_q != all-ones: target = lowest index with occ_q = 0; evict = 0.
    - Otherwise: target = rr_q; evict = 1; rr_q increments, wrapping DEPTH-1 -> 0.
    - Next state WR.
- WR: one-cycle pulse of cam_write_enable_o, with cam_write_index_o = target and cam_write_data_o = key_q. Set occ_q[target]. rsp_index = target. Next state RESP.
- RD: one-cycle pulse of cam_read_enable_o with cam_read_index_o = index_q. Next state RDCAP.
- RDCAP: capture cam_read_value_i into rsp_data and cam_read_valid_i into rsp_hit; rsp_index = index_q. Next state RESP.
- RESP:
  - rsp_valid_o = 1; all rsp_* fields are held stable until rsp_ready_i.
  - On rsp_ready_i, go to IDLE and clear the rsp_* fields.
  - No command is accepted while a response is pending, so at most one command is in flight.
- Latency from command handshake to rsp_valid_o:
  - LOOKUP, or INSERT that hits: 3 cycles.
  - INSERT that misses: 4 cycles.
  - READ: 3 cycles.
  - Reserved opcode: 1 cycle.
- The CAM enables are mutually exclusive and are never asserted outside SRCH, WR and RD.
- Data path is pass-through; there is no width arithmetic. rr_q is ADDR_WIDTH bits and wraps naturally.

Decomposition:
- Shared package cam_ctrl_pkg holds:
  - cam_op_e enum (OP_LOOKUP, OP_INSERT, OP_READ, OP_RSVD);
  - cam_ctrl_state_e enum;
  - DEPTH derivation.
- One sub-module, cam_free_finder. Combinational lowest-zero finder over occ_q, outputting free_index and any_free.

Test Plan:
1. Reset, then LOOKUP key 0xDEADBEEF -> rsp after 3 cycles: hit=0, index=0, evict=0; no CAM write pulse.
2. INSERT 0x11, 0x22, 0x33 -> indices 0, 1, 2, hit=0, each after 4 cycles. Then LOOKUP 0x22 -> hit=1, index=1.
3. INSERT 0x22 again -> hit=1, index=1; cam_write_enable_o never asserted; occ_q unchanged.
4. Fill 32 distinct keys 0x100..0x11F, then INSERT 0x200 -> index=0, evict=1. Next INSERT 0x201 -> index=1, evict=1. LOOKUP 0x100 -> hit=0.
5. READ index 2 after test 2 -> data=0x33, hit=1. READ index 7 -> hit=0.
6. Hold rsp_ready_i low for 5 cycles -> rsp_* stable and cmd_ready_o=0 throughout. Opcode 11 -> err=1 after 1 cycle. Assert rst_i during WR -> IDLE next cycle, no response, occ_q=0.
